// File: rtl/traffic_pkg.sv
// Shared phase encoding for the phase sequencer and the lamp driver decoder.
package traffic_pkg;

  localparam int PHASE_W = 2;

  localparam logic [PHASE_W-1:0] PH_IDLE   = 2'd0;
  localparam logic [PHASE_W-1:0] PH_GREEN  = 2'd1;
  localparam logic [PHASE_W-1:0] PH_YELLOW = 2'd2;
  localparam logic [PHASE_W-1:0] PH_CLEAR  = 2'd3;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE   = PH_IDLE,
    ST_GREEN  = PH_GREEN,
    ST_YELLOW = PH_YELLOW,
    ST_CLEAR  = PH_CLEAR
  } phase_t;

  // A duration is loadable when it is at least one cycle and fits a tw-bit timer.
  function automatic bit dur_ok(input int d, input int tw);
    return (d >= 1) && (longint'(d) < (longint'(1) << tw));
  endfunction

endpackage

// File: rtl/rr_prio_arbiter.sv
// Two-level rotated-priority arbiter: heavy requests beat light demand, and
// within each level the search starts just after the last-served approach.
module rr_prio_arbiter #(
  parameter int NUM_DIR = 4,
  localparam int IW = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic [NUM_DIR-1:0] heavy,
  input  logic [NUM_DIR-1:0] demand,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      winner
);

  logic          heavy_hit;
  logic          demand_hit;
  logic [IW-1:0] heavy_idx;
  logic [IW-1:0] demand_idx;
  logic [IW-1:0] idx;

  // Walk last+1 .. last (mod NUM_DIR); the first hit at each level wins.
  always_comb begin
    heavy_hit  = 1'b0;
    demand_hit = 1'b0;
    heavy_idx  = '0;
    demand_idx = '0;
    idx        = '0;
    for (int k = 1; k <= NUM_DIR; k++) begin
      idx = IW'((int'(last) + k) % NUM_DIR);
      if (!heavy_hit && heavy[idx]) begin
        heavy_hit = 1'b1;
        heavy_idx = idx;
      end
      if (!demand_hit && demand[idx]) begin
        demand_hit = 1'b1;
        demand_idx = idx;
      end
    end
    valid  = heavy_hit | demand_hit;
    winner = heavy_hit ? heavy_idx : demand_idx;
  end

endmodule

// File: rtl/adaptive_phase_sequencer.sv
// Round-robin traffic phase sequencer with one-shot green extension for heavy queues.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | all red, no requests; arbitrate every cycle
//  ST_GREEN  | active_dir has green; at timer 0 extend once if heavy, else yellow
//  ST_YELLOW | active_dir has yellow for YELLOW_T cycles
//  ST_CLEAR  | all-red clearance; at timer 0 regrant or fall back to idle
module adaptive_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int NUM_DIR   = 4,
  parameter int TW        = 8,
  parameter int MIN_GREEN = 20,
  parameter int EXT_GREEN = 10,
  parameter int YELLOW_T  = 5,
  parameter int CLEAR_T   = 2,
  localparam int IW = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DIR-1:0] demand,
  input  logic [NUM_DIR-1:0] heavy,
  output logic [PHASE_W-1:0] phase,
  output logic [IW-1:0]      active_dir,
  output logic               extended,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow
);

  if (NUM_DIR < 2) begin : g_bad_num_dir
    $error("adaptive_phase_sequencer: NUM_DIR must be at least 2");
  end
  if (!dur_ok(MIN_GREEN, TW)) begin : g_bad_min_green
    $error("adaptive_phase_sequencer: MIN_GREEN out of range for TW");
  end
  if (!dur_ok(EXT_GREEN, TW)) begin : g_bad_ext_green
    $error("adaptive_phase_sequencer: EXT_GREEN out of range for TW");
  end
  if (!dur_ok(YELLOW_T, TW)) begin : g_bad_yellow
    $error("adaptive_phase_sequencer: YELLOW_T out of range for TW");
  end
  if (!dur_ok(CLEAR_T, TW)) begin : g_bad_clear
    $error("adaptive_phase_sequencer: CLEAR_T out of range for TW");
  end

  localparam logic [TW-1:0] MIN_LD = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] EXT_LD = TW'(EXT_GREEN - 1);
  localparam logic [TW-1:0] YEL_LD = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] CLR_LD = TW'(CLEAR_T - 1);

  phase_t        state;
  logic [TW-1:0] timer;
  logic [IW-1:0] last;
  logic          arb_valid;
  logic [IW-1:0] arb_winner;

  rr_prio_arbiter #(.NUM_DIR(NUM_DIR)) u_arb (
    .heavy  (heavy),
    .demand (demand),
    .last   (last),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  // Phase FSM, down-counting phase timer, served pointer and extension flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      active_dir <= '0;
      last       <= IW'(NUM_DIR - 1);
      extended   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            state      <= ST_GREEN;
            active_dir <= arb_winner;
            last       <= arb_winner;
            timer      <= MIN_LD;
            extended   <= 1'b0;
          end
        end
        ST_GREEN: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (heavy[active_dir] && !extended) begin
            timer    <= EXT_LD;
            extended <= 1'b1;
          end else begin
            state <= ST_YELLOW;
            timer <= YEL_LD;
          end
        end
        ST_YELLOW: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state <= ST_CLEAR;
            timer <= CLR_LD;
          end
        end
        ST_CLEAR: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (arb_valid) begin
            state      <= ST_GREEN;
            active_dir <= arb_winner;
            last       <= arb_winner;
            timer      <= MIN_LD;
            extended   <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign phase = state;

  // Lamps decode only registered state, so inputs cannot glitch them.
  always_comb begin
    green  = '0;
    yellow = '0;
    if (state == ST_GREEN)  green[active_dir]  = 1'b1;
    if (state == ST_YELLOW) yellow[active_dir] = 1'b1;
  end

endmodule
